// File: rtl/bcd_time_counter_pkg.sv
// time_pkg: shared mode enum, BCD limits and BCD helpers for bcd_time_counter.
package time_pkg;
   typedef enum logic [1:0] {RUN = 2'd0, SET_HH = 2'd1, SET_MM = 2'd2} time_mode_t;
   localparam logic [7:0] SEC_MAX = 8'h59;
   localparam logic [7:0] MIN_MAX = 8'h59;
   localparam logic [7:0] HOUR_MAX = 8'h23;
   // {carry, next}: carry set when value is at max and wraps to 00
   function automatic logic [8:0] bcd_inc(input logic [7:0] value, input logic [7:0] max);
      return value == max ? 9'h100 :
             value[3:0] == 4'd9 ? {1'b0, value[7:4] + 4'd1, 4'd0} :
             {1'b0, value[7:4], value[3:0] + 4'd1};
   endfunction
   function automatic logic [7:0] to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction
   // {pm, hh} for a 12 h display of a 24 h BCD hour; hour 0 shows as 12
   function automatic logic [8:0] hour_to_12h(input logic [7:0] h24);
      logic [4:0] b;
      logic [4:0] h12;
      b = 5'(h24[7:4]) * 5'd10 + {1'b0, h24[3:0]};
      h12 = b >= 5'd12 ? b - 5'd12 : b;
      h12 = h12 == 5'd0 ? 5'd12 : h12;
      return {b >= 5'd12, h12 >= 5'd10 ? {4'd1, 4'(h12 - 5'd10)} : {4'd0, h12[3:0]}};
   endfunction
endpackage

// File: rtl/bcd_time_counter_if.sv
// bcd_time_counter_if: button/tick inputs and BCD time outputs of bcd_time_counter.
interface bcd_time_counter_if;
   logic tick_in;
   logic mode_btn;
   logic inc_btn;
   logic [7:0] hh;
   logic [7:0] mm;
   logic [7:0] ss;
   logic pm;
   logic [1:0] mode;
   logic sec_pulse;
   modport master(output tick_in, mode_btn, inc_btn, input hh, mm, ss, pm, mode, sec_pulse);
   modport slave(input tick_in, mode_btn, inc_btn, output hh, mm, ss, pm, mode, sec_pulse);
endinterface

// File: rtl/bcd_time_counter_mod.sv
// bcd_mod_counter: packed BCD mod-(MAX+1) counter; en is the cascade input and drives carry, inc steps without carry.
module bcd_mod_counter import time_pkg::*; #(
   parameter logic [7:0] MAX = SEC_MAX,
   parameter logic [7:0] INIT = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       inc,
   input  logic       clr,
   output logic [7:0] value,
   output logic       carry
);
   logic [8:0] nxt;
   assign nxt = bcd_inc(value, MAX);
   assign carry = en & nxt[8];
   always_ff @(posedge clk or posedge reset)
      if (reset) value <= INIT;
      else if (clr) value <= 8'h00;
      else if (en | inc) value <= nxt[7:0];
endmodule

// File: rtl/bcd_time_counter.sv
// bcd_time_counter: 1 Hz BCD hh:mm:ss clock with button set mode.
// Define CLOCK_12H_EN for a 12 h display with PM flag.
module bcd_time_counter import time_pkg::*; #(
   parameter int RESET_HH = 0,
   parameter int RESET_MM = 0
) (
   input logic clk,
   input logic reset,
   bcd_time_counter_if.slave bus
);
   logic tick_d, mode_d, inc_d;
   logic tick_rise, mode_rise, inc_rise;
   logic sec_inc, hh_inc, mm_inc, ss_clr;
   logic ss_c, mm_c, hh_unused;
   logic sec_pulse;
   logic [7:0] h24;
   time_mode_t state, state_n;
   assign tick_rise = bus.tick_in & ~tick_d;
   assign mode_rise = bus.mode_btn & ~mode_d;
   assign inc_rise = bus.inc_btn & ~inc_d;
   // tick_d starts high so a tick already high at reset release is not counted
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         tick_d <= 1'b1;
         mode_d <= 1'b0;
         inc_d <= 1'b0;
         sec_pulse <= 1'b0;
      end else begin
         tick_d <= bus.tick_in;
         mode_d <= bus.mode_btn;
         inc_d <= bus.inc_btn;
         sec_pulse <= sec_inc;
      end
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= RUN;
      else state <= state_n;
   always_comb
      state_n = !mode_rise ? state : state == RUN ? SET_HH : state == SET_HH ? SET_MM : RUN;
   // a mode rise in a set state swallows a simultaneous increment
   always_comb begin
      sec_inc = state == RUN && tick_rise;
      hh_inc = state == SET_HH && inc_rise && !mode_rise;
      mm_inc = state == SET_MM && inc_rise && !mode_rise;
      ss_clr = state == SET_MM && mode_rise;
   end
   bcd_mod_counter #(.MAX(SEC_MAX), .INIT(8'h00)) u_ss (
      .clk(clk), .reset(reset), .en(sec_inc), .inc(1'b0), .clr(ss_clr), .value(bus.ss), .carry(ss_c)
   );
   bcd_mod_counter #(.MAX(MIN_MAX), .INIT(to_bcd(RESET_MM))) u_mm (
      .clk(clk), .reset(reset), .en(ss_c), .inc(mm_inc), .clr(1'b0), .value(bus.mm), .carry(mm_c)
   );
   bcd_mod_counter #(.MAX(HOUR_MAX), .INIT(to_bcd(RESET_HH))) u_hh (
      .clk(clk), .reset(reset), .en(mm_c), .inc(hh_inc), .clr(1'b0), .value(h24), .carry(hh_unused)
   );
   assign bus.mode = state;
   assign bus.sec_pulse = sec_pulse;
`ifdef CLOCK_12H_EN
   assign {bus.pm, bus.hh} = hour_to_12h(h24);
`else
   assign bus.hh = h24;
   assign bus.pm = 1'b0;
`endif
endmodule
